// File: rtl/rx_serial_7o1.sv
// rx_serial_7o1: 7O1 asynchronous serial receiver (start, 7 data LSB first, odd parity, stop)
module rx_serial_7o1 #(
    parameter int M = 434,
    parameter int N = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    output logic [6:0] dados_ascii,
    output logic       paridade_ok,
    output logic       erro_stop,
    output logic       pronto,
    output logic       db_tick,
    output logic       db_dado_serial,
    output logic [3:0] db_estado
);
    localparam logic [3:0] IDLE        = 4'd0;
    localparam logic [3:0] START       = 4'd1;
    localparam logic [3:0] DADOS       = 4'd2;
    localparam logic [3:0] STOP        = 4'd3;
    localparam logic [3:0] FINAL       = 4'd4;
    localparam logic [3:0] ESPERA_ALTO = 4'd5;

    logic         s1, s2, stop_bit;
    logic [N-1:0] q;
    logic [3:0]   estado, cnt;
    logic [7:0]   shift;
    logic         fim, meio;

    assign fim  = q == N'(M - 1);
    assign meio = q == N'(M / 2 - 1);

    // Results are registered on the STOP->FINAL edge so they are valid while pronto is high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1          <= 1'b1;
            s2          <= 1'b1;
            q           <= '0;
            cnt         <= '0;
            shift       <= '0;
            stop_bit    <= 1'b0;
            estado      <= IDLE;
            dados_ascii <= '0;
            paridade_ok <= 1'b0;
            erro_stop   <= 1'b0;
        end else begin
            s1 <= dado_serial;
            s2 <= s1;
            q  <= fim ? '0 : q + N'(1);
            case (estado)
                IDLE: begin
                    q <= '0;
                    if (!s2) estado <= START;
                end
                START: begin
                    if (meio) begin
                        if (!s2) begin
                            q      <= '0;
                            cnt    <= '0;
                            estado <= DADOS;
                        end else begin
                            estado <= IDLE;
                        end
                    end
                end
                DADOS: begin
                    if (fim) begin
                        shift <= {s2, shift[7:1]};
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) estado <= STOP;
                    end
                end
                STOP: begin
                    if (fim) begin
                        stop_bit    <= s2;
                        dados_ascii <= shift[6:0];
                        paridade_ok <= ^shift;
                        erro_stop   <= ~s2;
                        estado      <= FINAL;
                    end
                end
                FINAL: estado <= stop_bit ? IDLE : ESPERA_ALTO;
                ESPERA_ALTO: begin
                    q <= '0;
                    if (s2) estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

    assign pronto         = estado == FINAL;
    assign db_tick        = fim;
    assign db_dado_serial = s2;
    assign db_estado      = estado;
endmodule

// File: tb/tb_rx_serial_7o1.sv
// tb_rx_serial_7o1: random and directed 7O1 frames checked against a frame-level reference
module tb_rx_serial_7o1;
    localparam int M = 16;
    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       dado_serial = 1'b1;
    logic [6:0] dados_ascii;
    logic       paridade_ok, erro_stop, pronto, db_tick, db_dado_serial;
    logic [3:0] db_estado;

    int vectors = 0;
    int miscompares = 0;
    int pronto_cnt = 0;
    int frames = 0;
    logic [8:0] exp_q[$];
    logic [8:0] e;

    rx_serial_7o1 #(.M(M), .N(N)) dut (
        .clock(clock), .reset(reset), .dado_serial(dado_serial),
        .dados_ascii(dados_ascii), .paridade_ok(paridade_ok), .erro_stop(erro_stop),
        .pronto(pronto), .db_tick(db_tick), .db_dado_serial(db_dado_serial),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every pronto cycle consumes one expected frame from the reference queue
    always @(negedge clock) begin
        if (pronto === 1'b1) begin
            pronto_cnt++;
            if (exp_q.size() == 0) check("unexpected_pronto", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("dados_ascii", 32'(dados_ascii), 32'(e[6:0]));
                check("paridade_ok", 32'(paridade_ok), 32'(e[7]));
                check("erro_stop", 32'(erro_stop), 32'(e[8]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [6:0] d, input logic p, input logic s);
        logic [9:0] f;
        f = {s, p, d, 1'b0};
        exp_q.push_back({~s, 1'(($countones({p, d}) % 2) == 1), d});
        frames++;
        for (int i = 0; i < 10; i++) begin
            dado_serial = f[i];
            idle(M);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_dados"}, 32'(dados_ascii), 32'd0);
        check({tag, "_par"}, 32'(paridade_ok), 32'd0);
        check({tag, "_err"}, 32'(erro_stop), 32'd0);
        check({tag, "_pronto"}, 32'(pronto), 32'd0);
        check({tag, "_estado"}, 32'(db_estado), 32'd0);
    endtask

    initial begin
        logic [6:0] d;
        logic s;
        #2 reset = 1'b1;
        idle(3);
        check_cleared("reset");
        check("reset_sync", 32'(db_dado_serial), 32'd1);
        reset = 1'b0;
        idle(5);

        send(7'h41, 1'b1, 1'b1);
        idle(M);
        check("hold_dados", 32'(dados_ascii), 32'h41);
        send(7'h41, 1'b0, 1'b1);
        idle(M);

        dado_serial = 1'b0;
        idle(4);
        check("glitch_start", 32'(db_estado), 32'd1);
        dado_serial = 1'b1;
        idle(2 * M);
        check("glitch_idle", 32'(db_estado), 32'd0);
        check("glitch_no_pronto", 32'(pronto_cnt), 32'(frames));

        reset = 1'b1;
        #1 check_cleared("rst_idle");
        idle(2);
        reset = 1'b0;
        idle(2);

        send(7'h3c, 1'b1, 1'b1);
        dado_serial = 1'b0;
        idle(M);
        dado_serial = 1'b1;
        idle(3 * M);
        check("mid_frame_dados", 32'(db_estado), 32'd2);
        reset = 1'b1;
        #1 check_cleared("rst_frame");
        idle(2);
        reset = 1'b0;
        idle(12 * M);
        check("rst_frame_no_pronto", 32'(pronto_cnt), 32'(frames));

        send(7'h00, 1'b1, 1'b0);
        idle(50 * M);
        check("break_espera", 32'(db_estado), 32'd5);
        check("break_one_pronto", 32'(pronto_cnt), 32'(frames));
        check("break_err_held", 32'(erro_stop), 32'd1);
        dado_serial = 1'b1;
        idle(4);
        check("break_release", 32'(db_estado), 32'd0);

        send(7'h55, ~^7'h55, 1'b1);
        send(7'h2a, ~^7'h2a, 1'b1);
        idle(M);

        for (int k = 0; k < 30; k++) begin
            d = 7'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send(d, ($urandom_range(0, 3) == 0) ? ^d : ~^d, s);
            dado_serial = 1'b1;
            idle(s ? $urandom_range(0, 3) : 2 * M);
        end

        idle(12 * M);
        check("all_frames_seen", 32'(exp_q.size()), 32'd0);
        check("pronto_count", 32'(pronto_cnt), 32'(frames));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
